// File: rtl/usb_reg_bridge_if.sv
// usb_reg_bridge_if: Wishbone slave side plus reg_cs/reg_ack register bus; slave = bridge, master = interconnect/target side
interface usb_reg_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [10:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        reg_cs;
  logic        reg_wr;
  logic [10:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        reg_err;
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i, reg_rdata, reg_ack, reg_err,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
  );
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i, reg_rdata, reg_ack, reg_err,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o, reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
  );
endinterface

// File: rtl/usb_reg_bridge.sv
// usb_reg_bridge: Wishbone slave (bus) to reg_cs/reg_ack bridge with ack timeout and saturating timeout count (tmo_cnt)
module usb_reg_bridge #(
  parameter int TIMEOUT = 255,
  parameter int TCNT_W  = 8
) (
  input  logic             app_clk,
  input  logic             reset_ssn,
  usb_reg_bridge_if.slave  bus,
  output logic [7:0]       tmo_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t            state;
  logic [TCNT_W-1:0] cnt;
  logic              abort;
  logic              timeout;
  logic              drop;
  logic              done;
  assign timeout = (TIMEOUT != 0) && (cnt == TCNT_W'(TIMEOUT));
  assign drop    = abort | ~bus.wbs_cyc_i;
  assign done    = bus.reg_ack | bus.reg_err | timeout;
  always_ff @(posedge app_clk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      state         <= IDLE;
      cnt           <= '0;
      abort         <= 1'b0;
      tmo_cnt       <= '0;
      bus.wbs_dat_o <= '0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_err_o <= 1'b0;
      bus.reg_cs    <= 1'b0;
      bus.reg_wr    <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_be    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          state         <= REQ;
          cnt           <= '0;
          abort         <= 1'b0;
          bus.reg_cs    <= 1'b1;
          bus.reg_wr    <= bus.wbs_we_i;
          bus.reg_addr  <= bus.wbs_adr_i;
          bus.reg_wdata <= bus.wbs_dat_i;
          bus.reg_be    <= bus.wbs_sel_i;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (!bus.wbs_cyc_i) abort <= 1'b1;
          if (done) begin
            state         <= RESP;
            bus.reg_cs    <= 1'b0;
            bus.wbs_ack_o <= bus.reg_ack & ~bus.reg_err & ~drop;
            bus.wbs_err_o <= (bus.reg_err | ~bus.reg_ack) & ~drop;
            bus.wbs_dat_o <= (bus.reg_ack && !bus.reg_err && !bus.reg_wr) ? bus.reg_rdata : '0;
            if (!bus.reg_ack && !bus.reg_err && tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.wbs_ack_o <= 1'b0;
          bus.wbs_err_o <= 1'b0;
          bus.wbs_dat_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
